// File: rtl/sift_pkg.sv
// Shared constants and state encoding for the SIFT difference-of-Gaussians front end.
package sift_pkg;

    localparam int SIFT_BIT_DEPTH = 8;
    localparam int SIFT_WIDTH     = 64;
    localparam int SIFT_HEIGHT    = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dog_state_t;

endpackage

// File: rtl/dog_pipe_delay.sv
// Fixed-depth shift register that carries {valid, addr} alongside the BRAM read path.
module dog_pipe_delay #(
    parameter int W     = 1,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [DEPTH];

    // Shift chain; every stage clears on reset so no stale valid survives an abort.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dog_img.sv
// Difference-of-Gaussians frame engine: streams A-B from two blurred BRAMs into a DoG BRAM.
// Optional build macro DOG_CLAMP_EN saturates the difference to the signed BIT_DEPTH range.
module dog_img
    import sift_pkg::*;
#(
    parameter int BIT_DEPTH = SIFT_BIT_DEPTH,
    parameter int WIDTH     = SIFT_WIDTH,
    parameter int HEIGHT    = SIFT_HEIGHT,
    localparam int N        = WIDTH * HEIGHT,
    localparam int AW       = $clog2(N)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    output logic [AW-1:0]        ext_read_addr,
    output logic                 ext_read_addr_valid,
    input  logic [BIT_DEPTH-1:0] ext_pixel_a_in,
    input  logic [BIT_DEPTH-1:0] ext_pixel_b_in,
    output logic [AW-1:0]        ext_write_addr,
    output logic                 ext_write_valid,
    output logic [BIT_DEPTH:0]   ext_pixel_out,
    output logic                 busy_out,
    output logic                 dog_done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    dog_state_t          state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic                drain_q, drain_d;
    logic                data_valid_q;
    logic [BIT_DEPTH:0]  pixel_q;
    logic                read_valid_s;
    logic                busy_s;
    logic                done_s;
    logic                wr_valid_s;
    logic [AW-1:0]       wr_addr_s;
    logic signed [BIT_DEPTH:0] full_s;
    logic signed [BIT_DEPTH:0] diff_s;

    // State, address counter and drain counter registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            addr_q  <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic; the address saturates at the last pixel and never wraps.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                addr_d  = '0;
                drain_d = 1'b0;
                if (start_in) begin
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            DRAIN: begin
                if (drain_q) begin
                    state_d = DONE;
                    drain_d = 1'b0;
                end else begin
                    drain_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode straight from the state register.
    always_comb begin
        read_valid_s = 1'b0;
        busy_s       = 1'b1;
        done_s       = 1'b0;
        case (state_q)
            IDLE:    busy_s       = 1'b0;
            READ:    read_valid_s = 1'b1;
            DRAIN:   busy_s       = 1'b1;
            DONE:    done_s       = 1'b1;
            default: busy_s       = 1'b0;
        endcase
    end

    // Two-cycle issue-to-write latency: BRAM output register plus the difference register.
    dog_pipe_delay #(
        .W     (AW + 1),
        .DEPTH (2)
    ) u_delay (
        .clk_i   (clk_in),
        .rst_n_i (rst_in),
        .d_i     ({read_valid_s, addr_q}),
        .q_o     ({wr_valid_s, wr_addr_s})
    );

    assign full_s = $signed({1'b0, ext_pixel_a_in}) - $signed({1'b0, ext_pixel_b_in});

`ifdef DOG_CLAMP_EN
    localparam logic signed [BIT_DEPTH:0] CLAMP_MAX = {2'b00, {(BIT_DEPTH-1){1'b1}}};
    localparam logic signed [BIT_DEPTH:0] CLAMP_MIN = {2'b11, {(BIT_DEPTH-1){1'b0}}};

    // Saturate to the signed BIT_DEPTH range, kept sign-extended on BIT_DEPTH+1 bits.
    always_comb begin
        if (full_s > CLAMP_MAX) begin
            diff_s = CLAMP_MAX;
        end else if (full_s < CLAMP_MIN) begin
            diff_s = CLAMP_MIN;
        end else begin
            diff_s = full_s;
        end
    end
`else
    assign diff_s = full_s;
`endif

    // Difference register; data is valid one cycle after the address is issued.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            data_valid_q <= 1'b0;
            pixel_q      <= '0;
        end else begin
            data_valid_q <= read_valid_s;
            if (data_valid_q) begin
                pixel_q <= diff_s;
            end else begin
                pixel_q <= pixel_q;
            end
        end
    end

    assign ext_read_addr       = addr_q;
    assign ext_read_addr_valid = read_valid_s;
    assign ext_write_addr      = wr_addr_s;
    assign ext_write_valid     = wr_valid_s;
    assign ext_pixel_out       = pixel_q;
    assign busy_out            = busy_s;
    assign dog_done            = done_s;

endmodule

// File: tb/tb_dog_img.sv
// Scoreboard bench for dog_img: random/pattern frames, reference model from image arrays.
module tb_dog_img;

    localparam int BD = 8;
    localparam int W  = 64;
    localparam int H  = 64;
    localparam int N  = W * H;
    localparam int AW = $clog2(N);
    localparam int NO_FRAME = -1000000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] raddr, waddr;
    logic          rvalid, wvalid, busy, done;
    logic [BD-1:0] pa = '0;
    logic [BD-1:0] pb = '0;
    logic [BD:0]   pout;

    always #5 clk = ~clk;

    dog_img #(.BIT_DEPTH(BD), .WIDTH(W), .HEIGHT(H)) dut (
        .clk_in              (clk),
        .rst_in              (rst_n),
        .start_in            (start),
        .ext_read_addr       (raddr),
        .ext_read_addr_valid (rvalid),
        .ext_pixel_a_in      (pa),
        .ext_pixel_b_in      (pb),
        .ext_write_addr      (waddr),
        .ext_write_valid     (wvalid),
        .ext_pixel_out       (pout),
        .busy_out            (busy),
        .dog_done            (done)
    );

    logic [BD-1:0] mem_a [N];
    logic [BD-1:0] mem_b [N];

    // Blurred-image BRAMs: registered read, data one cycle after the address.
    always @(posedge clk) begin
        if (rvalid) begin
            pa <= mem_a[raddr];
            pb <= mem_b[raddr];
        end
    end

    typedef struct { int addr; int data; int cyc; } wr_t;
    wr_t wq[$];
    int  dq[$];
    int  cyc = 0;
    int  frame_t = NO_FRAME;
    int  busy_cnt = 0;
    int  checks = 0;
    int  passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int model_diff(input int a, input int b);
        int d;
        d = a - b;
`ifdef DOG_CLAMP_EN
        if (d > (1 << (BD-1)) - 1) d = (1 << (BD-1)) - 1;
        if (d < -(1 << (BD-1)))    d = -(1 << (BD-1));
`endif
        return d;
    endfunction

    // Monitor: compares writes/done against the queues and read/busy against the frame window.
    always @(negedge clk) begin
        wr_t e;
        int  ed;
        bit  exp_busy, exp_rv;
        if (wvalid) begin
            if (wq.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = wq.pop_front();
                check("wr_addr", int'(waddr), e.addr);
                check("wr_data", int'($signed(pout)), e.data);
                check("wr_cycle", cyc, e.cyc);
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                ed = dq.pop_front();
                check("done_cycle", cyc, ed);
            end
        end
        exp_busy = (cyc >= frame_t + 1) && (cyc <= frame_t + N + 3);
        exp_rv   = (cyc >= frame_t + 1) && (cyc <= frame_t + N);
        check("busy", int'(busy), int'(exp_busy));
        check("rd_valid", int'(rvalid), int'(exp_rv));
        if (exp_rv) check("rd_addr", int'(raddr), cyc - frame_t - 1);
        if (busy) busy_cnt++;
    end

    task automatic fill_const(input int a, input int b);
        for (int i = 0; i < N; i++) begin
            mem_a[i] = BD'(a);
            mem_b[i] = BD'(b);
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < N; i++) begin
            mem_a[i] = i[BD-1:0];
            mem_b[i] = i[BD-1:0] >> 1;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++) begin
            mem_a[i] = BD'($urandom_range(255, 0));
            mem_b[i] = BD'($urandom_range(255, 0));
        end
    endtask

    // Called in a negedge slot: queues the whole frame's expectations, then pulses start.
    task automatic start_frame(output int t);
        t = cyc;
        for (int i = 0; i < N; i++) begin
            wq.push_back('{addr: i, data: model_diff(int'(mem_a[i]), int'(mem_b[i])), cyc: t + 3 + i});
        end
        dq.push_back(t + N + 3);
        frame_t  = t;
        busy_cnt = 0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < N + 20 && (dq.size() != 0 || wq.size() != 0); i++) begin
            @(negedge clk);
            #1;
        end
        check("frame_complete", dq.size() + wq.size(), 0);
    endtask

    task automatic pulse_start_at(input int c);
        while (cyc < c) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_rvalid"}, int'(rvalid), 0);
        check({tag, "_wvalid"}, int'(wvalid), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pout"}, int'(pout), 0);
        check({tag, "_raddr"}, int'(raddr), 0);
        check({tag, "_waddr"}, int'(waddr), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Constant images: +150 everywhere, start accepted on the first edge after reset.
        fill_const(200, 50);
        start_frame(t);
        wait_done();
        check("busy_cycles_const", busy_cnt, N + 3);

        // Negative extreme, with a start pulse mid-frame and one in the DONE cycle.
        @(negedge clk);
        fill_const(0, 255);
        start_frame(t);
        pulse_start_at(t + 5);
        pulse_start_at(t + N + 3);
        wait_done();
        repeat (6) @(negedge clk);

        // Positive extreme.
        fill_const(255, 0);
        start_frame(t);
        wait_done();

        // Ramp image: every write is A-B at its own address.
        @(negedge clk);
        fill_ramp();
        start_frame(t);
        wait_done();
        check("busy_cycles_ramp", busy_cnt, N + 3);

        // Random frame aborted by reset at t+8, then a fresh random frame right after release.
        @(negedge clk);
        fill_rand();
        start_frame(t);
        while (cyc < t + 8) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        wq.delete();
        dq.delete();
        frame_t = NO_FRAME;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fill_rand();
        start_frame(t);
        wait_done();
        check("busy_cycles_rand", busy_cnt, N + 3);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
